// File: rtl/alu_flag_branch_unit.sv
// ---------------------------------------------------------------------------
// alu_flag_branch_unit
//
// EX-stage companion to the pipeline ALU. It captures the compare flags of
// compare instructions into a flag register and evaluates conditional
// branches against those flags. A taken branch produces a registered
// one-cycle redirect to fetch and a flush of the wrong-path stages that
// lasts FLUSH_CYCLES cycles.
//
// Optional build macro: ALU_FLAG_BYPASS_EN
//   When defined, a branch that arrives together with a flag write is
//   evaluated on the incoming ALU flags (compare+branch back-to-back).
//   When undefined, branches always use the registered flags.
//
// Parameters:
//   PC_WIDTH      width of PC, branch offset and target
//   FLUSH_CYCLES  cycles flush_o stays high per taken branch (1..15)
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   stall_i             HDU stall; freezes flag capture and branch evaluation
//   flag_we_i           EX instruction is a compare; capture flags
//   alu_a_gt_b_i        ALU a>b flag
//   alu_a_lt_b_i        ALU a<b flag
//   zero_i              ALU a==b flag
//   cout_i              ALU carry out
//   br_valid_i          EX instruction is a conditional branch
//   br_cond_i           condition code
//   pc_i                PC of the branch
//   br_offset_i         two's-complement word offset
//   br_taken_o          one-cycle redirect pulse
//   br_target_o         redirect PC (held after the pulse)
//   flush_o             squash IF/ID/EX contents
//   flags_o             flag register {gt, lt, eq, c}
//   busy_o              high while flushing
// ---------------------------------------------------------------------------
module alu_flag_branch_unit #(
    parameter int PC_WIDTH     = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                flag_we_i,
    input  logic                alu_a_gt_b_i,
    input  logic                alu_a_lt_b_i,
    input  logic                zero_i,
    input  logic                cout_i,
    input  logic                br_valid_i,
    input  logic [3:0]          br_cond_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] br_offset_i,
    output logic                br_taken_o,
    output logic [PC_WIDTH-1:0] br_target_o,
    output logic                flush_o,
    output logic [3:0]          flags_o,
    output logic                busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Counter is loaded with the number of flush cycles still to come after
    // the first one, so FLUSH leaves on the edge where it reads zero.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    logic [0:0]          state_q,  state_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic [3:0]          flags_q,  flags_d;
    logic                taken_q,  taken_d;
    logic [PC_WIDTH-1:0] target_q, target_d;

    logic                accept;
    logic                take;
    logic [3:0]          alu_flags;
    logic [3:0]          eval_flags;

    // Flag layout {gt, lt, eq, c}.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
        logic gt, lt, eq, c;
        gt = f[3];
        lt = f[2];
        eq = f[1];
        c  = f[0];
        case (cond)
            4'b0000: cond_met = eq;
            4'b0001: cond_met = !eq;
            4'b0010: cond_met = gt;
            4'b0011: cond_met = lt;
            4'b0100: cond_met = gt | eq;
            4'b0101: cond_met = lt | eq;
            4'b0110: cond_met = c;
            4'b0111: cond_met = !c;
            4'b1110: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

    always_comb begin
        accept    = (state_q == ST_IDLE) && !stall_i;
        alu_flags = {alu_a_gt_b_i, alu_a_lt_b_i, zero_i, cout_i};

`ifdef ALU_FLAG_BYPASS_EN
        eval_flags = flag_we_i ? alu_flags : flags_q;
`else
        eval_flags = flags_q;
`endif

        take = accept && br_valid_i && cond_met(br_cond_i, eval_flags);

        taken_d  = take;
        flags_d  = (accept && flag_we_i) ? alu_flags : flags_q;
        // Offset is two's complement; the PC_WIDTH-bit sum wraps modulo
        // 2^PC_WIDTH, which is the intended target arithmetic.
        target_d = take ? (pc_i + br_offset_i) : target_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LAST;
                end
            end
            default: begin
                // Flush timing is independent of stall_i.
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            flags_q  <= 4'b0000;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign br_taken_o  = taken_q;
    assign br_target_o = target_q;
    assign flush_o     = (state_q == ST_FLUSH);
    assign busy_o      = (state_q == ST_FLUSH);
    assign flags_o     = flags_q;

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
module tb_alu_flag_branch_unit;

    localparam int PW = 9;
    localparam int FC = 2;
`ifdef ALU_FLAG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall, we, gt, lt, zero, cout, bv;
    logic [3:0]    cond;
    logic [PW-1:0] pc, off;
    logic          taken_o, flush_o, busy_o;
    logic [PW-1:0] target_o;
    logic [3:0]    flags_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0]    m_flags;
    int            m_left;      // flush cycles remaining, including current
    logic          m_taken;
    logic [PW-1:0] m_target;

    always #5 clk = ~clk;

    alu_flag_branch_unit #(.PC_WIDTH(PW), .FLUSH_CYCLES(FC)) dut (
        .clock        (clk),
        .reset        (rst),
        .stall_i      (stall),
        .flag_we_i    (we),
        .alu_a_gt_b_i (gt),
        .alu_a_lt_b_i (lt),
        .zero_i       (zero),
        .cout_i       (cout),
        .br_valid_i   (bv),
        .br_cond_i    (cond),
        .pc_i         (pc),
        .br_offset_i  (off),
        .br_taken_o   (taken_o),
        .br_target_o  (target_o),
        .flush_o      (flush_o),
        .flags_o      (flags_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Branch condition from its mnemonic meaning.
    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit g, l, e, cy;
        g = f[3]; l = f[2]; e = f[1]; cy = f[0];
        case (c)
            4'd0:  return e;          // EQ
            4'd1:  return !e;         // NE
            4'd2:  return g;          // GT
            4'd3:  return l;          // LT
            4'd4:  return g || e;     // GE
            4'd5:  return l || e;     // LE
            4'd6:  return cy;         // CS
            4'd7:  return !cy;        // CC
            4'd14: return 1'b1;       // AL
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags  = 4'b0000;
        m_left   = 0;
        m_taken  = 1'b0;
        m_target = '0;
    endtask

    task automatic model_edge();
        logic [3:0] inc, f;
        int soff, tgt;
        if (rst) begin
            model_reset();
            return;
        end
        inc     = {gt, lt, zero, cout};
        m_taken = 1'b0;
        if (m_left > 0) begin
            m_left--;
        end else if (!stall) begin
            if (bv) begin
                f = (BYP && we) ? inc : m_flags;
                if (cond_true(cond, f)) begin
                    soff     = int'($signed(off));
                    tgt      = (int'(pc) + soff + (1 << PW)) % (1 << PW);
                    m_taken  = 1'b1;
                    m_target = tgt[PW-1:0];
                    m_left   = FC;
                end
            end
            if (we) m_flags = inc;
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".taken"},  taken_o,  m_taken);
        check({tag, ".target"}, target_o, m_target);
        check({tag, ".flush"},  flush_o,  m_left > 0);
        check({tag, ".busy"},   busy_o,   m_left > 0);
        check({tag, ".flags"},  flags_o,  m_flags);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs(tag);
    endtask

    task automatic quiet();
        stall = 0; we = 0; gt = 0; lt = 0; zero = 0; cout = 0;
        bv = 0; cond = 4'd0; pc = '0; off = '0;
    endtask

    task automatic compare(input logic g, input logic l, input logic z, input logic c);
        quiet();
        we = 1; gt = g; lt = l; zero = z; cout = c;
    endtask

    task automatic branch(input logic [3:0] cc, input logic [PW-1:0] p, input logic [PW-1:0] o);
        quiet();
        bv = 1; cond = cc; pc = p; off = o;
    endtask

    initial begin
        quiet();
        model_reset();
        rst = 1;
        #12;
        compare_outputs("reset");
        rst = 0;
        tick("idle0");

        // Compare eq, then BEQ
        compare(0, 0, 1, 0);
        tick("cmp_eq");
        check("cmp_eq.flags_const", flags_o, 4'b0010);
        branch(4'd0, 9'h010, 9'h005);
        tick("beq");
        check("beq.taken_const", taken_o, 1'b1);
        check("beq.tgt_const", target_o, 9'h015);
        quiet();
        tick("beq_f2");
        check("beq_f2.flush_const", flush_o, 1'b1);
        check("beq_f2.taken_const", taken_o, 1'b0);
        tick("beq_f3");
        check("beq_f3.flush_const", flush_o, 1'b0);
        check("beq_f3.tgt_hold", target_o, 9'h015);

        // Compare gt, BLE not taken, BGT with negative offset
        compare(1, 0, 0, 0);
        tick("cmp_gt");
        branch(4'd5, 9'h020, 9'h004);
        tick("ble");
        check("ble.taken_const", taken_o, 1'b0);
        check("ble.flush_const", flush_o, 1'b0);
        branch(4'd2, 9'h020, 9'h1FE);
        tick("bgt");
        check("bgt.tgt_const", target_o, 9'h01E);
        quiet();
        tick("bgt_f2");
        tick("bgt_f3");

        // Wrap-around AL
        branch(4'd14, 9'h1FF, 9'h003);
        tick("al_wrap");
        check("al_wrap.tgt_const", target_o, 9'h002);
        quiet();
        tick("wrap_f2");
        tick("wrap_f3");

        // Wrong-path compare+branch during flush with stall toggling
        branch(4'd14, 9'h040, 9'h010);
        tick("al_fl");
        compare(0, 1, 0, 1);
        bv = 1; cond = 4'd14; pc = 9'h100; off = 9'h001; stall = 1;
        tick("wp1");
        stall = 0;
        tick("wp2");
        check("wp2.flush_end", flush_o, 1'b0);
        check("wp2.flags_kept", flags_o, 4'b1000);
        check("wp2.tgt_kept", target_o, 9'h050);
        quiet();
        tick("wp3");

        // Reset in the middle of a flush
        branch(4'd14, 9'h080, 9'h002);
        tick("al_rst");
        quiet();
        #2;
        rst = 1;
        #1;
        model_reset();
        compare_outputs("async_rst");
        check("async_rst.flush_const", flush_o, 1'b0);
        tick("rst_hold");
        rst = 0;
        branch(4'd14, 9'h030, 9'h001);
        tick("al_after_rst");
        check("al_after_rst.tgt_const", target_o, 9'h031);
        quiet();
        tick("ar_f2");
        tick("ar_f3");

        // Same-cycle compare(eq) + BEQ, flags cleared first
        compare(0, 0, 0, 0);
        tick("clr_flags");
        compare(0, 0, 1, 0);
        bv = 1; cond = 4'd0; pc = 9'h060; off = 9'h008;
        tick("same");
        check("same.taken_const", taken_o, BYP);
        check("same.flags_const", flags_o, 4'b0010);
        quiet();
        tick("same_f2");
        tick("same_f3");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            we    = ($urandom_range(0, 2) == 0);
            gt    = 1'($urandom);
            lt    = 1'($urandom);
            zero  = 1'($urandom);
            cout  = 1'($urandom);
            bv    = 1'($urandom);
            cond  = 4'($urandom);
            pc    = PW'($urandom);
            off   = PW'($urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
